loader_write_bridge: RTL and testbench

LOADER_WRITE_BRIDGE -- requirements
Module: loader_write_bridge

---
 rtl/loader_write_bridge.sv | 216 +++++++++++++++++++++
 tb/tb_loader_write_bridge.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/loader_write_bridge.sv
// ----------------------------------------------------------------------------
// loader_write_bridge
//
// Buffers byte writes from the game loader and replays them into SDRAM, one
// write per memory slot. A small FIFO absorbs loader bursts. A two-state FSM
// presents each entry on mem_we/mem_addr/mem_data for one whole slot period.
//
// Parameters
//   DEPTH        FIFO entries (power of two, >= 2)
//
// Ports
//   clk          core clock
//   reset        synchronous, active-high reset
//   in_valid     one-cycle write strobe from the loader
//   in_addr      22-bit target byte address (PRG 0x000000, CHR 0x200000)
//   in_data      byte to write
//   slot         one-cycle memory-slot pulse
//   mem_we       SDRAM write request, held for one slot period per byte
//   mem_addr     SDRAM write address (registered)
//   mem_data     SDRAM write data (registered)
//   busy         FIFO non-empty or write in progress
//   overflow     sticky: a loader byte was dropped on a full FIFO
//   byte_count   bytes issued to SDRAM, modulo 2^22
//   checksum     16-bit running sum of issued bytes; this port exists only
//                when LOADER_BRIDGE_CHECKSUM_EN is defined
//
// Optional feature macro: LOADER_BRIDGE_CHECKSUM_EN
// ----------------------------------------------------------------------------
module loader_write_bridge #(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [21:0] in_addr,
   input  logic [7:0]  in_data,
   input  logic        slot,
   output logic        mem_we,
   output logic [21:0] mem_addr,
   output logic [7:0]  mem_data,
   output logic        busy,
   output logic        overflow,
   output logic [21:0] byte_count
`ifdef LOADER_BRIDGE_CHECKSUM_EN
   ,
   output logic [15:0] checksum
`endif
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam int unsigned EW = 30;
   localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

   typedef enum logic [0:0] {
      StIdle,
      StWrite
   } state_e;

   state_e        state_q, state_d;

   logic [EW-1:0] fifo_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic          mem_we_q, mem_we_d;
   logic [21:0]   mem_addr_q, mem_addr_d;
   logic [7:0]    mem_data_q, mem_data_d;
   logic          overflow_q, overflow_d;
   logic [21:0]   byte_count_q, byte_count_d;

   logic          empty, full;
   logic          push, pop, drop;
   logic [EW-1:0] head;

   // ---------------------------------------------------------------------
   // FIFO control
   // ---------------------------------------------------------------------
   // A pop happens on every slot while data is queued, whichever state the
   // FSM is in: in StIdle it starts a write, in StWrite it chains the next
   // one. Emptiness is taken from the registered count, so a byte pushed in
   // the same cycle as a slot cannot be popped until a later slot.
   always_comb begin
      empty = (count_q == '0);
      full  = (count_q == FullCnt);
      pop   = slot && !empty;
      // A full FIFO still accepts a byte when the head leaves this cycle.
      push  = in_valid && (!full || pop);
      drop  = in_valid && full && !pop;
      head  = fifo_q[rd_ptr_q];
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         fifo_q[wr_ptr_q] <= {in_addr, in_data};
      end
   end

   // ---------------------------------------------------------------------
   // Write FSM
   // ---------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      mem_we_d   = mem_we_q;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;

      unique case (state_q)
         StIdle: begin
            if (pop) begin
               state_d    = StWrite;
               mem_we_d   = 1'b1;
               mem_addr_d = head[29:8];
               mem_data_d = head[7:0];
            end
         end
         StWrite: begin
            // Outputs hold until the slot that closes this write.
            if (slot) begin
               if (pop) begin
                  mem_addr_d = head[29:8];
                  mem_data_d = head[7:0];
               end else begin
                  state_d  = StIdle;
                  mem_we_d = 1'b0;
               end
            end
         end
         default: begin
            state_d  = StIdle;
            mem_we_d = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Status
   // ---------------------------------------------------------------------
   always_comb begin
      overflow_d   = overflow_q | drop;
      byte_count_d = byte_count_q + {21'd0, pop};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         overflow_q   <= 1'b0;
         byte_count_q <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
         overflow_q   <= overflow_d;
         byte_count_q <= byte_count_d;
      end
   end

`ifdef LOADER_BRIDGE_CHECKSUM_EN
   logic [15:0] checksum_q, checksum_d;

   // Sums the byte being loaded onto mem_data at each pop.
   always_comb begin
      checksum_d = checksum_q;
      if (pop) begin
         checksum_d = checksum_q + {8'd0, head[7:0]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         checksum_q <= '0;
      end else begin
         checksum_q <= checksum_d;
      end
   end

   assign checksum = checksum_q;
`endif

   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_data   = mem_data_q;
   assign busy       = (count_q != '0) || mem_we_q;
   assign overflow   = overflow_q;
   assign byte_count = byte_count_q;

endmodule

// File: tb/tb_loader_write_bridge.sv
`timescale 1ns/1ps
module tb_loader_write_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [21:0] in_addr;
   logic [7:0]  in_data;
   logic        slot;
   logic        mem_we;
   logic [21:0] mem_addr;
   logic [7:0]  mem_data;
   logic        busy;
   logic        overflow;
   logic [21:0] byte_count;
`ifdef LOADER_BRIDGE_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   int checks = 0;
   int errors = 0;

   // Slot sources: a periodic generator (every 4th clk) and a manual pulse.
   logic slot_en  = 1'b0;
   logic slot_gen = 1'b0;
   logic slot_man = 1'b0;
   int   phase    = 0;
   assign slot = slot_gen | slot_man;

   // Observed write windows.
   logic [21:0] wl_addr[$];
   logic [7:0]  wl_data[$];
   int          wl_len[$];
   int          we_falls = 0;
   logic        prev_we = 1'b0;
   logic [21:0] prev_addr = '0;
   logic [7:0]  prev_data = '0;

   loader_write_bridge #(.DEPTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_addr    (in_addr),
      .in_data    (in_data),
      .slot       (slot),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .busy       (busy),
      .overflow   (overflow),
      .byte_count (byte_count)
`ifdef LOADER_BRIDGE_CHECKSUM_EN
      ,
      .checksum   (checksum)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (!slot_en) begin
            phase    = 0;
            slot_gen = 1'b0;
         end else begin
            slot_gen = (phase == 0);
            phase    = (phase + 1) % 4;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (mem_we === 1'b1) begin
            if (!prev_we || mem_addr !== prev_addr || mem_data !== prev_data) begin
               wl_addr.push_back(mem_addr);
               wl_data.push_back(mem_data);
               wl_len.push_back(1);
            end else begin
               wl_len[wl_len.size()-1] = wl_len[wl_len.size()-1] + 1;
            end
         end
         if (prev_we && mem_we !== 1'b1) we_falls++;
         prev_we   = (mem_we === 1'b1);
         prev_addr = mem_addr;
         prev_data = mem_data;
      end
   end

   task automatic clear_log();
      wl_addr.delete();
      wl_data.delete();
      wl_len.delete();
      we_falls = 0;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      slot_man = 1'b0;
      slot_en  = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", mem_we); end
      checks++; if (mem_addr !== 22'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
      checks++; if (mem_data !== 8'h0) begin errors++; $display("FAIL reset_data: got %h want 0", mem_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
      checks++; if (byte_count !== 22'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", byte_count); end
`ifdef LOADER_BRIDGE_CHECKSUM_EN
      checks++; if (checksum !== 16'h0) begin errors++; $display("FAIL reset_sum: got %h want 0", checksum); end
`endif
      // Slots with an empty FIFO must do nothing.
      clear_log();
      slot_en = 1'b1;
      repeat (12) @(negedge clk);
      slot_en = 1'b0;
      checks++; if (wl_addr.size() != 0) begin errors++; $display("FAIL idle_slot_writes: got %0d want 0", wl_addr.size()); end
      checks++; if (byte_count !== 22'd0) begin errors++; $display("FAIL idle_slot_cnt: got %0d want 0", byte_count); end
   endtask

   task automatic test_latency();
      do_reset();
      // Push and slot in the same cycle: the byte must not be popped yet.
      in_addr = 22'h3FFFFF; in_data = 8'h5A; in_valid = 1'b1; slot_man = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; slot_man = 1'b0;
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL same_cycle_we: got %b want 0", mem_we); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL same_cycle_busy: got %b want 1", busy); end
      slot_man = 1'b1;
      @(negedge clk);
      slot_man = 1'b0;
      checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL lat_we: got %b want 1", mem_we); end
      checks++; if (mem_addr !== 22'h3FFFFF) begin errors++; $display("FAIL lat_addr: got %h want 3fffff", mem_addr); end
      checks++; if (mem_data !== 8'h5A) begin errors++; $display("FAIL lat_data: got %h want 5a", mem_data); end
      checks++; if (byte_count !== 22'd1) begin errors++; $display("FAIL lat_cnt: got %0d want 1", byte_count); end
      repeat (3) @(negedge clk);
      checks++; if (mem_we !== 1'b1 || mem_data !== 8'h5A) begin errors++; $display("FAIL hold: got we=%b data=%h want 1/5a", mem_we, mem_data); end
      slot_man = 1'b1;
      @(negedge clk);
      slot_man = 1'b0;
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL end_we: got %b want 0", mem_we); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL end_busy: got %b want 0", busy); end
   endtask

   task automatic test_single();
      do_reset();
      clear_log();
      slot_en = 1'b1;
      repeat (2) @(negedge clk);
      in_addr = 22'h000010; in_data = 8'hA5; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (30) @(negedge clk);
      checks++; if (wl_addr.size() != 1) begin errors++; $display("FAIL single_n: got %0d want 1", wl_addr.size()); end
      if (wl_addr.size() >= 1) begin
         checks++; if (wl_addr[0] !== 22'h000010) begin errors++; $display("FAIL single_addr: got %h want 000010", wl_addr[0]); end
         checks++; if (wl_data[0] !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", wl_data[0]); end
         checks++; if (wl_len[0] != 4) begin errors++; $display("FAIL single_len: got %0d want 4", wl_len[0]); end
      end
      checks++; if (byte_count !== 22'd1) begin errors++; $display("FAIL single_cnt: got %0d want 1", byte_count); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", busy); end
`ifdef LOADER_BRIDGE_CHECKSUM_EN
      checks++; if (checksum !== 16'h00A5) begin errors++; $display("FAIL single_sum: got %h want 00a5", checksum); end
`endif
   endtask

   task automatic test_back_to_back();
      do_reset();
      clear_log();
      slot_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_addr = 22'h200000 + 22'(i); in_data = 8'(i + 1); in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      repeat (40) @(negedge clk);
      checks++; if (wl_addr.size() != 4) begin errors++; $display("FAIL b2b_n: got %0d want 4", wl_addr.size()); end
      for (int i = 0; i < 4 && i < wl_addr.size(); i++) begin
         checks++; if (wl_addr[i] !== 22'h200000 + 22'(i)) begin errors++; $display("FAIL b2b_addr%0d: got %h want %h", i, wl_addr[i], 22'h200000 + 22'(i)); end
         checks++; if (wl_data[i] !== 8'(i + 1)) begin errors++; $display("FAIL b2b_data%0d: got %h want %h", i, wl_data[i], 8'(i + 1)); end
         checks++; if (wl_len[i] != 4) begin errors++; $display("FAIL b2b_len%0d: got %0d want 4", i, wl_len[i]); end
      end
      checks++; if (we_falls != 1) begin errors++; $display("FAIL b2b_gaps: got %0d falls want 1", we_falls); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b want 0", overflow); end
      checks++; if (byte_count !== 22'd4) begin errors++; $display("FAIL b2b_cnt: got %0d want 4", byte_count); end
`ifdef LOADER_BRIDGE_CHECKSUM_EN
      checks++; if (checksum !== 16'h000A) begin errors++; $display("FAIL b2b_sum: got %h want 000a", checksum); end
`endif
   endtask

   task automatic test_overflow();
      do_reset();
      clear_log();
      for (int i = 0; i < 5; i++) begin
         in_addr = 22'h000100 + 22'(i); in_data = 8'h11 + 8'(i); in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL ovf_we: got %b want 0", mem_we); end
      slot_en = 1'b1;
      repeat (40) @(negedge clk);
      checks++; if (byte_count !== 22'd4) begin errors++; $display("FAIL ovf_cnt: got %0d want 4", byte_count); end
      checks++; if (wl_addr.size() != 4) begin errors++; $display("FAIL ovf_n: got %0d want 4", wl_addr.size()); end
      if (wl_addr.size() >= 4) begin
         checks++; if (wl_data[3] !== 8'h14) begin errors++; $display("FAIL ovf_last: got %h want 14", wl_data[3]); end
      end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
   endtask

   task automatic test_full_pop();
      do_reset();
      clear_log();
      for (int i = 0; i < 4; i++) begin
         in_addr = 22'h000040 + 22'(i); in_data = 8'h21 + 8'(i); in_valid = 1'b1;
         @(negedge clk);
      end
      // Full FIFO: push coincides with a popping slot.
      in_addr = 22'h000044; in_data = 8'h25; in_valid = 1'b1; slot_man = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; slot_man = 1'b0;
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fp_ovf: got %b want 0", overflow); end
      checks++; if (mem_we !== 1'b1 || mem_data !== 8'h21) begin errors++; $display("FAIL fp_first: got we=%b data=%h want 1/21", mem_we, mem_data); end
      slot_en = 1'b1;
      repeat (40) @(negedge clk);
      checks++; if (byte_count !== 22'd5) begin errors++; $display("FAIL fp_cnt: got %0d want 5", byte_count); end
      checks++; if (wl_data.size() != 5) begin errors++; $display("FAIL fp_n: got %0d want 5", wl_data.size()); end
      for (int i = 0; i < 5 && i < wl_data.size(); i++) begin
         checks++; if (wl_data[i] !== 8'h21 + 8'(i)) begin errors++; $display("FAIL fp_data%0d: got %h want %h", i, wl_data[i], 8'h21 + 8'(i)); end
      end
      checks++; if (we_falls != 1) begin errors++; $display("FAIL fp_gaps: got %0d falls want 1", we_falls); end
   endtask

   task automatic test_reset_mid_write();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         in_addr = 22'h000080 + 22'(i); in_data = 8'h31 + 8'(i); in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0; slot_man = 1'b1;
      @(negedge clk);
      slot_man = 1'b0;
      checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rmw_pre_we: got %b want 1", mem_we); end
      // Reset with loader and slot activity that must be ignored.
      reset = 1'b1; in_data = 8'h77; in_valid = 1'b1; slot_man = 1'b1;
      @(negedge clk);
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rmw_we: got %b want 0", mem_we); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmw_busy: got %b want 0", busy); end
      checks++; if (byte_count !== 22'd0) begin errors++; $display("FAIL rmw_cnt: got %0d want 0", byte_count); end
      reset = 1'b0; in_valid = 1'b0; slot_man = 1'b0;
      clear_log();
      slot_en = 1'b1;
      repeat (30) @(negedge clk);
      checks++; if (wl_addr.size() != 0) begin errors++; $display("FAIL rmw_writes: got %0d want 0", wl_addr.size()); end
      checks++; if (byte_count !== 22'd0) begin errors++; $display("FAIL rmw_cnt_after: got %0d want 0", byte_count); end
   endtask

   task automatic test_stream();
      do_reset();
      clear_log();
      slot_en = 1'b1;
      for (int i = 0; i < 256; i++) begin
         in_addr = 22'(i); in_data = 8'hFF; in_valid = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
         repeat (3) @(negedge clk);
      end
      repeat (20) @(negedge clk);
      checks++; if (byte_count !== 22'd256) begin errors++; $display("FAIL stream_cnt: got %0d want 256", byte_count); end
      checks++; if (wl_addr.size() != 256) begin errors++; $display("FAIL stream_n: got %0d want 256", wl_addr.size()); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL stream_ovf: got %b want 0", overflow); end
`ifdef LOADER_BRIDGE_CHECKSUM_EN
      checks++; if (checksum !== 16'hFF00) begin errors++; $display("FAIL stream_sum: got %h want ff00", checksum); end
`endif
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_addr  = '0;
      in_data  = '0;
      test_reset();
      test_latency();
      test_single();
      test_back_to_back();
      test_overflow();
      test_full_pop();
      test_reset_mid_write();
      test_stream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
